// File: rtl/iterative_shifter_left.sv
// Multi-cycle left logical shifter: one power-of-two stage per clock, always
// nb_bits_shift stages, with a start/busy/done handshake and a held result.
module iterative_shifter_left #(
    parameter int nb_bits_data  = 32,
    parameter int nb_bits_shift = $clog2(nb_bits_data)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [nb_bits_data-1:0]  data_i,
    input  logic [nb_bits_shift-1:0] shamt_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [nb_bits_data-1:0]  data_o
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [nb_bits_shift-1:0] LastStage = nb_bits_shift'(nb_bits_shift - 1);

    state_t                     state_q, state_d;
    logic [nb_bits_data-1:0]    acc_q, acc_d;
    logic [nb_bits_shift-1:0]   amt_q, amt_d;
    logic [nb_bits_shift-1:0]   cnt_q, cnt_d;
    logic [nb_bits_data-1:0]    data_q, data_d;

    logic [nb_bits_data-1:0]    stride;
    logic                       take;
    logic [nb_bits_data-1:0]    stage;

    // Stage cnt shifts by 2^cnt when bit cnt of the captured amount is set.
    assign stride = nb_bits_data'(1) << cnt_q;
    assign take   = |(amt_q & (nb_bits_shift'(1) << cnt_q));
    assign stage  = take ? (acc_q << stride) : acc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            amt_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            amt_q   <= amt_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        amt_d   = amt_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d   = data_i;
                    amt_d   = shamt_i;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = stage;
                cnt_d = cnt_q + nb_bits_shift'(1);
                if (cnt_q == LastStage) begin
                    data_d  = stage;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign data_o = data_q;

endmodule

// File: doc/iterative_shifter_left.md
# iterative_shifter_left

Multi-cycle left logical shifter for the RV32I execute stage, serving SLL/SLLI when the single-cycle barrel path is not instantiated. It decomposes the shift amount into power-of-two stages and applies one stage per clock. Operands are accepted with a start/busy/done handshake, and the result is held stable until the next accepted operation. It is the left-shift counterpart of the fixed right-arithmetic shift stages.

## Interface

**Parameters**
- `nb_bits_data`, default 32: operand and result width. Must be a power of two, ≥ 2.
- `nb_bits_shift`, default `$clog2(nb_bits_data)` = 5: shift-amount width and number of shift stages.

**Ports**
- `clk_i`, input, 1: the single clock. All state updates on the rising edge.
- `rst_i`, input, 1: reset. Asynchronous and active-high.
- `start_i`, input, 1: request a shift. Sampled only in IDLE.
- `data_i`, input, `nb_bits_data`: operand. Captured on the accepting edge.
- `shamt_i`, input, `nb_bits_shift`: shift amount. Captured on the accepting edge.
- `busy_o`, output, 1: high whenever the state is not IDLE.
- `done_o`, output, 1: one-cycle pulse while the state is DONE.
- `data_o`, output, `nb_bits_data`: result register. Updated only on entry to DONE.

## Operation

- **State register:** states IDLE, SHIFT, DONE. Internal registers:
  - working register `acc`, `nb_bits_data` wide
  - captured amount `amt`, `nb_bits_shift` wide
  - stage counter `cnt`, `nb_bits_shift` wide
- **IDLE**
  - If `start_i`=1 on an edge: `acc`←`data_i`, `amt`←`shamt_i`, `cnt`←0, state←SHIFT.
  - Otherwise hold.
- **SHIFT**
  - Each edge: if `amt[cnt]`=1, `acc`←`acc` << 2^`cnt` with zero fill from the LSB side; otherwise `acc` is unchanged.
  - `cnt`←`cnt`+1 on each edge.
  - On the edge where `cnt`=`nb_bits_shift`−1: `data_o`←the stage result of that same edge, and state←DONE.
- **DONE:** `done_o`=1. The next edge returns the state to IDLE unconditionally.
- **Fixed latency:** all `nb_bits_shift` stages always execute, including when `shamt_i`=0. There is no early exit.
- **Result width:** bits shifted out past the MSB are discarded. A result of 0 is legal.
- **Ignored start:** `start_i` while `busy_o`=1 (SHIFT or DONE) is ignored and not queued. The running operation is unaffected.
- **Input sampling:** `data_i` and `shamt_i` are don't-care except on the accepting edge. Changes during SHIFT have no effect.
- **Result stability:** `data_o` changes only on entry to DONE and holds through IDLE indefinitely.
- **Reset (asynchronous `rst_i`=1, at any time including mid-SHIFT)**
  - state←IDLE; `acc`, `amt`, `cnt`←0.
  - `data_o`←0, `busy_o`=0, `done_o`=0.
  - The in-flight operation is dropped and produces no `done_o`.
- **Reset release:** first acceptance is possible on the first edge with `rst_i`=0 and `start_i`=1.

## Timing

- **Reset values:** `busy_o`=0, `done_o`=0, `data_o`=0.
- **Edge numbering:** call the accepting edge E0.
  - `busy_o` rises after E0.
  - SHIFT occupies the cycles after E0 … E(`nb_bits_shift`−1).
  - `data_o` is valid and `done_o`=1 in the cycle after E(`nb_bits_shift`), i.e. after E5 for the defaults.
  - `busy_o` and `done_o` fall after E(`nb_bits_shift`+1).
- **Latency:** `nb_bits_shift` edges from acceptance to `done_o`. Throughput is one operation per `nb_bits_shift`+2 cycles.
- **Back-to-back:** a `start_i` held high continuously is accepted at E0, E7, E14, … with the defaults.
- **Decoding:** `busy_o` and `done_o` are decoded from the state register only, with no combinational path from inputs.

## Test plan

- **Reset values:** assert `rst_i` with no clock running → `data_o`=0x00000000, `busy_o`=0, `done_o`=0 immediately, without a clock edge.
- **Basic shift:** `data_i`=0x00000001, `shamt_i`=31, start → `done_o` pulses exactly 5 edges after acceptance, for one cycle; `data_o`=0x80000000.
- **Shift by zero and by one:**
  - `data_i`=0xDEADBEEF, `shamt_i`=0 → `data_o`=0xDEADBEEF after the full 5-edge latency.
  - Then `shamt_i`=1 → `data_o`=0xBD5B7DDE.
- **Overflow discard:** `data_i`=0xF000000F, `shamt_i`=4 → `data_o`=0x000000F0.
  - `start_i` pulsed again mid-SHIFT with `data_i`=0x1 → ignored; only one `done_o` pulse is produced.
  - `data_i` changed during SHIFT → no effect on the result.
- **Reset mid-operation:** accept `data_i`=0x12345678, `shamt_i`=8; assert `rst_i` after E2 → `busy_o`=0 and `data_o`=0 at once; no `done_o` follows; the next operation (0x3, `shamt_i`=2) returns 0x0000000C.
- **Back-to-back:** `start_i` held high with operands 0xA→`shamt_i` 3, then 0xFFFFFFFF→`shamt_i` 16 → acceptances 7 edges apart; results 0x00000050 then 0xFFFF0000; `data_o` holds 0x50 until the second DONE.
